// File: rtl/snn_layer_sequencer.sv
// Layer/time-step sequencer for the SNN datapath: walks every post-synaptic neuron of every
// layer per time step, issuing weight, spike and potential addresses plus accumulator strobes.
module snn_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int NW         = 7,
    parameter int T_W        = 8,
    parameter int W_ADDR_W   = 11,
    parameter int MEM_ADDR_W = 9,
    parameter int RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stall,
    input  logic [T_W-1:0]                cfg_num_steps,
    input  logic [NUM_LAYERS*NW-1:0]      cfg_layer_sizes,
    output logic                          busy,
    output logic                          done,
    output logic [T_W-1:0]                time_step,
    output logic [$clog2(NUM_LAYERS)-1:0] layer,
    output logic [W_ADDR_W-1:0]           w_read_sram_addr,
    output logic [MEM_ADDR_W-1:0]         spk_read_addr,
    output logic                          spk_read_en,
    output logic                          ac_reset,
    output logic                          ac_en,
    output logic                          ac_oen,
    output logic [MEM_ADDR_W-2:0]         potential_read_addr,
    output logic [MEM_ADDR_W-2:0]         potential_write_addr,
    output logic                          potential_write_we,
    output logic [MEM_ADDR_W-1:0]         spk_write_addr,
    output logic                          spk_write_we
);
    localparam int LW = $clog2(NUM_LAYERS);
    localparam int PW = MEM_ADDR_W - 1;
    localparam int SW = NUM_LAYERS * NW;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_FIRE, S_DONE} state_t;
    state_t state, state_d;

    logic [SW-1:0]       sizes_q;
    logic [T_W-1:0]      t_q, last_t_q;
    logic [LW-1:0]       l_q;
    logic [NW-1:0]       i_q, j_q;
    logic [W_ADDR_W-1:0] w_q;
    logic [PW-1:0]       base_prev_q, base_cur_q, post_idx;
    logic [1:0]          drain_q;

    logic [NW-1:0] sz_prev, sz_cur;
    logic          last_pre, last_post, last_layer, last_step, drain_end;
    int            prev_idx;

    // A zero size field is read as a single neuron.
    function automatic logic [NW-1:0] field(input logic [SW-1:0] v, input int idx);
        logic [NW-1:0] f;
        f = v[idx*NW +: NW];
        return (f == '0) ? NW'(1) : f;
    endfunction

    always_comb begin
        prev_idx   = (l_q == '0) ? 0 : int'(l_q) - 1;
        sz_prev    = field(sizes_q, prev_idx);
        sz_cur     = field(sizes_q, int'(l_q));
        last_pre   = (i_q == sz_prev - NW'(1));
        last_post  = (j_q == sz_cur - NW'(1));
        last_layer = (l_q == LW'(NUM_LAYERS - 1));
        last_step  = (t_q == last_t_q);
        drain_end  = (drain_q == 2'(RD_LAT - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_ACCUM;
            S_ACCUM: if (last_pre) state_d = (RD_LAT == 0) ? S_FIRE : S_DRAIN;
            S_DRAIN: if (drain_end) state_d = S_FIRE;
            S_FIRE:  state_d = (last_post && last_layer && last_step) ? S_DONE : S_CLEAR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // start is honoured in IDLE even with stall high
        if (stall && state != S_IDLE) state_d = state;
    end

    always_comb begin
        busy               = (state != S_IDLE);
        done               = (state == S_DONE)  && !stall;
        ac_reset           = (state == S_CLEAR) && !stall;
        ac_en              = (state == S_ACCUM) && !stall;
        spk_read_en        = (state == S_ACCUM) && !stall;
        ac_oen             = (state == S_FIRE)  && !stall;
        potential_write_we = (state == S_FIRE)  && !stall;
        spk_write_we       = (state == S_FIRE)  && !stall;
    end

    assign post_idx             = base_cur_q + PW'(j_q);
    assign time_step            = t_q;
    assign layer                = l_q;
    assign w_read_sram_addr     = w_q;
    assign spk_read_addr        = {t_q[0], base_prev_q + PW'(i_q)};
    assign potential_read_addr  = post_idx;
    assign potential_write_addr = post_idx;
    assign spk_write_addr       = {t_q[0], post_idx};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sizes_q     <= '0;
            last_t_q    <= '0;
            t_q         <= '0;
            l_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            w_q         <= '0;
            base_prev_q <= '0;
            base_cur_q  <= '0;
            drain_q     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sizes_q     <= cfg_layer_sizes;
                    last_t_q    <= (cfg_num_steps == '0) ? '0 : cfg_num_steps - T_W'(1);
                    t_q         <= '0;
                    l_q         <= LW'(1);
                    i_q         <= '0;
                    j_q         <= '0;
                    w_q         <= '0;
                    base_prev_q <= '0;
                    base_cur_q  <= PW'(field(cfg_layer_sizes, 0));
                    drain_q     <= '0;
                end
                S_CLEAR: if (!stall) i_q <= '0;
                S_ACCUM: if (!stall) begin
                    i_q     <= i_q + NW'(1);
                    w_q     <= w_q + W_ADDR_W'(1);
                    drain_q <= '0;
                end
                S_DRAIN: if (!stall) drain_q <= drain_q + 2'd1;
                S_FIRE: if (!stall) begin
                    if (!last_post) begin
                        j_q <= j_q + NW'(1);
                    end else if (!last_layer) begin
                        j_q         <= '0;
                        l_q         <= l_q + LW'(1);
                        base_prev_q <= base_cur_q;
                        base_cur_q  <= base_cur_q + PW'(sz_cur);
                    end else if (!last_step) begin
                        j_q         <= '0;
                        t_q         <= t_q + T_W'(1);
                        l_q         <= LW'(1);
                        w_q         <= '0;
                        base_prev_q <= '0;
                        base_cur_q  <= PW'(field(sizes_q, 0));
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Bench for snn_layer_sequencer: a per-cycle expected-activity queue built from the layer/step
// loop nest is checked cycle by cycle; a second RD_LAT=0 build is checked for run length.
`timescale 1ns/1ps
module tb_snn_layer_sequencer;
    localparam int NL = 3, NW = 7, T_W = 8, WA = 11, MA = 9, PW = 8, LW = 2;
    localparam int K_CLR = 0, K_ACC = 1, K_DRN = 2, K_FIRE = 3, K_DONE = 4;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start0 = 1'b0, stall = 1'b0, stall0 = 1'b0;
    logic [T_W-1:0]   cfg_num_steps = '0;
    logic [NL*NW-1:0] cfg_layer_sizes = '0;

    logic busy, done, spk_read_en, ac_reset, ac_en, ac_oen, potential_write_we, spk_write_we;
    logic [T_W-1:0] time_step;
    logic [LW-1:0]  layer;
    logic [WA-1:0]  w_read_sram_addr;
    logic [MA-1:0]  spk_read_addr, spk_write_addr;
    logic [PW-1:0]  potential_read_addr, potential_write_addr;

    logic busy_z, done_z, sre_z, acr_z, ace_z, aco_z, pwe_z, swe_z;
    logic [T_W-1:0] ts_z;
    logic [LW-1:0]  layer_z;
    logic [WA-1:0]  w_z;
    logic [MA-1:0]  sra_z, swa_z;
    logic [PW-1:0]  pra_z, pwa_z;

    snn_layer_sequencer #(.NUM_LAYERS(NL), .NW(NW), .T_W(T_W), .W_ADDR_W(WA),
                          .MEM_ADDR_W(MA), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .cfg_num_steps(cfg_num_steps), .cfg_layer_sizes(cfg_layer_sizes),
        .busy(busy), .done(done), .time_step(time_step), .layer(layer),
        .w_read_sram_addr(w_read_sram_addr), .spk_read_addr(spk_read_addr),
        .spk_read_en(spk_read_en), .ac_reset(ac_reset), .ac_en(ac_en), .ac_oen(ac_oen),
        .potential_read_addr(potential_read_addr), .potential_write_addr(potential_write_addr),
        .potential_write_we(potential_write_we), .spk_write_addr(spk_write_addr),
        .spk_write_we(spk_write_we));

    snn_layer_sequencer #(.NUM_LAYERS(NL), .NW(NW), .T_W(T_W), .W_ADDR_W(WA),
                          .MEM_ADDR_W(MA), .RD_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .stall(stall0),
        .cfg_num_steps(cfg_num_steps), .cfg_layer_sizes(cfg_layer_sizes),
        .busy(busy_z), .done(done_z), .time_step(ts_z), .layer(layer_z),
        .w_read_sram_addr(w_z), .spk_read_addr(sra_z),
        .spk_read_en(sre_z), .ac_reset(acr_z), .ac_en(ace_z), .ac_oen(aco_z),
        .potential_read_addr(pra_z), .potential_write_addr(pwa_z),
        .potential_write_we(pwe_z), .spk_write_addr(swa_z),
        .spk_write_we(swe_z));

    always #5 clk = ~clk;

    typedef struct { int kind; int t; int l; int w; int sra; int pra; int swa; } rec_t;
    rec_t exp_q[$];
    int   wr_log[$];
    int   total = 0, bad = 0;
    int   run_cyc = 0, last_len = 0, cnt0 = 0, exp0 = 0, last0 = 0;

    function automatic void chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic int norm(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Closed-form run length: steps * sum size(l)*(size(l-1)+rdlat+2) plus the DONE cycle.
    function automatic int run_len(input int s0, s1, s2, steps, rdlat);
        int a0, a1, a2;
        a0 = norm(s0); a1 = norm(s1); a2 = norm(s2);
        return norm(steps) * (a1 * (a0 + rdlat + 2) + a2 * (a1 + rdlat + 2)) + 1;
    endfunction

    // Expected activity, one record per unstalled cycle, for the RD_LAT=1 instance.
    task automatic build(input int s0, s1, s2, steps);
        int s[NL];
        int base[NL];
        int w, bank;
        rec_t r;
        s[0] = norm(s0); s[1] = norm(s1); s[2] = norm(s2);
        base[0] = 0;
        for (int l = 1; l < NL; l++) base[l] = (base[l-1] + s[l-1]) % 256;
        for (int t = 0; t < norm(steps); t++) begin
            w = 0;
            bank = (t % 2) * 256;
            for (int l = 1; l < NL; l++) begin
                for (int j = 0; j < s[l]; j++) begin
                    r.t = t; r.l = l; r.w = 0; r.sra = 0; r.swa = 0;
                    r.pra = (base[l] + j) % 256;
                    r.kind = K_CLR; exp_q.push_back(r);
                    for (int i = 0; i < s[l-1]; i++) begin
                        r.kind = K_ACC;
                        r.w = w % 2048;
                        r.sra = bank + (base[l-1] + i) % 256;
                        exp_q.push_back(r);
                        w++;
                    end
                    r.kind = K_DRN; exp_q.push_back(r);
                    r.kind = K_FIRE; r.swa = bank + r.pra; exp_q.push_back(r);
                end
            end
        end
        r.kind = K_DONE; r.t = norm(steps) - 1; r.l = NL - 1;
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        rec_t r;
        int   sv;
        if (!reset) begin
            chk("rst_ctrl", int'({busy, done, ac_reset, ac_en, spk_read_en, ac_oen,
                                  potential_write_we, spk_write_we}), 0);
            chk("rst_addr", int'(w_read_sram_addr) + int'(spk_read_addr) + int'(potential_read_addr)
                + int'(potential_write_addr) + int'(spk_write_addr) + int'(time_step) + int'(layer), 0);
            chk("rst_rdlat0", int'(|{busy_z, done_z, sre_z, acr_z, ace_z, aco_z, pwe_z, swe_z,
                                     ts_z, layer_z, w_z, sra_z, swa_z, pra_z, pwa_z}), 0);
            exp_q.delete();
            run_cyc = 0;
            cnt0 = 0;
        end else begin
            if (busy_z) cnt0++;
            if (done_z) begin
                chk("rdlat0_len", cnt0, exp0);
                last0 = cnt0;
                cnt0 = 0;
            end
            if (exp_q.size() == 0) begin
                chk("idle_ctrl", int'({busy, done, ac_reset, ac_en, spk_read_en, ac_oen,
                                       potential_write_we, spk_write_we}), 0);
            end else begin
                r = exp_q[0];
                run_cyc++;
                case (r.kind)
                    K_CLR:   sv = 32;
                    K_ACC:   sv = 24;
                    K_FIRE:  sv = 7;
                    K_DONE:  sv = 64;
                    default: sv = 0;
                endcase
                if (stall) sv = 0;
                chk("busy", int'(busy), 1);
                chk("strobes", int'({done, ac_reset, ac_en, spk_read_en, ac_oen,
                                     potential_write_we, spk_write_we}), sv);
                chk("time_step", int'(time_step), r.t);
                chk("layer", int'(layer), r.l);
                if (r.kind == K_ACC) begin
                    chk("w_addr", int'(w_read_sram_addr), r.w);
                    chk("spk_rd_addr", int'(spk_read_addr), r.sra);
                end
                if (r.kind != K_DONE) chk("pot_rd_addr", int'(potential_read_addr), r.pra);
                if (r.kind == K_FIRE) begin
                    chk("pot_wr_addr", int'(potential_write_addr), r.pra);
                    chk("spk_wr_addr", int'(spk_write_addr), r.swa);
                    if (!stall) wr_log.push_back(int'(spk_write_addr));
                end
                if (!stall) begin
                    void'(exp_q.pop_front());
                    if (r.kind == K_DONE) begin
                        last_len = run_cyc;
                        run_cyc = 0;
                    end
                end
            end
        end
    end

    task automatic hard_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // mode: 0 no stall, 1 random stall, 2 stall cycles 8..11 after start
    task automatic run_one(input int s0, s1, s2, steps, mode, midstart);
        int cyc, budget;
        @(posedge clk); #1;
        cfg_layer_sizes = {NW'(s2), NW'(s1), NW'(s0)};
        cfg_num_steps   = T_W'(steps);
        start = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start0 = 1'b0;
        wr_log.delete();
        build(s0, s1, s2, steps);
        exp0   = run_len(s0, s1, s2, steps, 0);
        budget = 5 * run_len(s0, s1, s2, steps, 1) + 20;
        cyc = 1;
        while (exp_q.size() != 0 && cyc < budget) begin
            cfg_layer_sizes = (NL*NW)'($urandom());
            cfg_num_steps   = T_W'($urandom());
            case (mode)
                1:       stall = ($urandom_range(0, 3) == 0);
                2:       stall = (cyc >= 8 && cyc < 12);
                default: stall = 1'b0;
            endcase
            start = (midstart != 0) && (cyc == 2 || cyc == 4);
            @(posedge clk); #1;
            cyc++;
        end
        stall = 1'b0;
        start = 1'b0;
        chk("run_timeout", exp_q.size(), 0);
        if (exp_q.size() != 0) hard_reset();
    endtask

    task automatic run_reset();
        int guard;
        @(posedge clk); #1;
        cfg_layer_sizes = {NW'(2), NW'(3), NW'(2)};
        cfg_num_steps   = T_W'(1);
        start = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start0 = 1'b0;
        build(2, 3, 2, 1);
        exp0 = run_len(2, 3, 2, 1, 0);
        guard = 0;
        while (exp_q.size() != 0 && exp_q[0].kind != K_FIRE && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_fire", (exp_q.size() != 0) ? exp_q[0].kind : -1, K_FIRE);
        reset = 1'b0;
        #2;
        chk("async_busy", int'(busy), 0);
        chk("async_we", int'({ac_oen, potential_write_we, spk_write_we}), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_one(2, 3, 2, 1, 0, 0);
        chk("basic_len", last_len, 28);
        chk("basic_len_rdlat0", last0, 23);
        chk("basic_nwr", wr_log.size(), 5);
        for (int k = 0; k < 5; k++)
            chk("basic_wr", (k < wr_log.size()) ? wr_log[k] : -1, 2 + k);

        run_one(2, 3, 2, 2, 0, 0);
        chk("two_step_len", last_len, 55);
        chk("step1_first_wr", (wr_log.size() > 5) ? wr_log[5] : -1, 'h102);

        run_one(2, 3, 2, 1, 2, 0);
        chk("stall_len", last_len, 32);

        run_reset();
        run_one(2, 3, 2, 1, 0, 0);
        chk("after_reset_len", last_len, 28);

        run_one(0, 0, 0, 0, 0, 1);
        chk("zero_cfg_len", last_len, 9);

        run_one(120, 100, 60, 1, 1, 0);

        repeat (12) begin
            int a, b, c, st, md, ms;
            a  = $urandom_range(0, 6);
            b  = $urandom_range(0, 6);
            c  = $urandom_range(0, 6);
            st = $urandom_range(0, 3);
            md = $urandom_range(0, 1);
            ms = $urandom_range(0, 1);
            run_one(a, b, c, st, md, ms);
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
